// File: rtl/spi_sd_frame_receiver.sv
// spi_sd_frame_receiver
// Parses SD-style command frames arriving one byte per io_BufferChanged strobe:
// start byte, ARG_BYTES argument bytes, then a CRC7/end-bit byte. An accepted
// frame may be followed by a start-token data block whose bytes are streamed
// out one per strobe, followed by two CRC16 bytes that are consumed unchecked.
// Optional feature macro: SPI_RX_CRC7_CHECK_EN (compute and verify the CRC7).
// Without it only the end bit of the CRC byte is checked.

module spi_sd_frame_receiver #(
  parameter int ARG_BYTES = 4,
  parameter int BLKSZ_W   = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_CS,
  input  logic [7:0]             io_InputBuffer,
  input  logic                   io_BufferChanged,
  input  logic                   io_DataExpected,
  input  logic [BLKSZ_W-1:0]     io_DataBlockSize,
  output logic                   io_CommandValid,
  output logic [5:0]             io_Command,
  output logic [8*ARG_BYTES-1:0] io_CommandArgument,
  output logic                   io_FrameError,
  output logic [7:0]             io_DataOut,
  output logic                   io_DataValid,
  output logic                   io_DataDone,
  output logic [2:0]             io_State
);

  localparam int ARG_W = 8 * ARG_BYTES;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARG   = 3'd1;
  localparam logic [2:0] ST_CRC   = 3'd2;
  localparam logic [2:0] ST_TOKEN = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DCRC  = 3'd5;

  localparam logic [2:0] ARG_LAST    = 3'(ARG_BYTES - 1);
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [2:0]         arg_cnt;
  logic [BLKSZ_W-1:0] data_cnt;
  logic [BLKSZ_W-1:0] blk_size;
  logic               dcrc_cnt;
  logic [5:0]         pend_cmd;
  logic [ARG_W-1:0]   pend_arg;

  logic strobe;
  logic is_start;
  logic arg_last;
  logic data_last;
  logic crc_ok;
  logic frame_ok;
  logic token_bad;

  // A byte is only acted on when chip select is low; CS high always wins.
  assign strobe    = io_BufferChanged & ~io_CS;
  assign is_start  = (io_InputBuffer[7:6] == 2'b01);
  assign arg_last  = (arg_cnt == ARG_LAST);
  assign data_last = (data_cnt == blk_size - BLKSZ_W'(1));
  assign token_bad = (io_InputBuffer != START_TOKEN) && (io_InputBuffer != FILL_BYTE);
  assign frame_ok  = io_InputBuffer[0] & crc_ok;
  assign io_State  = state;

`ifdef SPI_RX_CRC7_CHECK_EN
  logic [6:0] crc_reg;

  // One byte of CRC7 (x^7 + x^3 + 1), processed MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign crc_ok = (crc_reg == io_InputBuffer[7:1]);

  // Running CRC7 over the start byte and the argument bytes of the current frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_reg <= 7'd0;
    end else if (io_CS) begin
      crc_reg <= 7'd0;
    end else if (strobe) begin
      if (state == ST_IDLE && is_start) begin
        crc_reg <= crc7_byte(7'd0, io_InputBuffer);
      end else if (state == ST_ARG) begin
        crc_reg <= crc7_byte(crc_reg, io_InputBuffer);
      end
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

  // Next-state decode: one transition per accepted byte, CS high forces IDLE.
  always_comb begin
    state_nxt = state;
    if (io_CS) begin
      state_nxt = ST_IDLE;
    end else if (io_BufferChanged) begin
      case (state)
        ST_IDLE: begin
          if (is_start) state_nxt = ST_ARG;
        end
        ST_ARG: begin
          if (arg_last) state_nxt = ST_CRC;
        end
        ST_CRC: begin
          if (frame_ok && io_DataExpected) state_nxt = ST_TOKEN;
          else                             state_nxt = ST_IDLE;
        end
        ST_TOKEN: begin
          if (io_InputBuffer == START_TOKEN) begin
            if (io_DataBlockSize == '0) state_nxt = ST_DCRC;
            else                        state_nxt = ST_DATA;
          end else if (token_bad) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (data_last) state_nxt = ST_DCRC;
        end
        ST_DCRC: begin
          if (dcrc_cnt) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte counters and the block size captured at the start token.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arg_cnt  <= 3'd0;
      data_cnt <= '0;
      blk_size <= '0;
      dcrc_cnt <= 1'b0;
    end else if (io_CS) begin
      arg_cnt  <= 3'd0;
      data_cnt <= '0;
      dcrc_cnt <= 1'b0;
    end else if (strobe) begin
      case (state)
        ST_IDLE: begin
          arg_cnt <= 3'd0;
        end
        ST_ARG: begin
          if (arg_last) arg_cnt <= 3'd0;
          else          arg_cnt <= arg_cnt + 3'd1;
        end
        ST_TOKEN: begin
          if (io_InputBuffer == START_TOKEN) begin
            blk_size <= io_DataBlockSize;
            data_cnt <= '0;
            dcrc_cnt <= 1'b0;
          end
        end
        ST_DATA: begin
          if (data_last) data_cnt <= '0;
          else           data_cnt <= data_cnt + BLKSZ_W'(1);
        end
        ST_DCRC: begin
          dcrc_cnt <= ~dcrc_cnt;
        end
        default: ;
      endcase
    end
  end

  // Pending command and argument, assembled MSB first until the CRC byte decides.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_cmd <= 6'd0;
      pend_arg <= '0;
    end else if (strobe) begin
      if (state == ST_IDLE && is_start) begin
        pend_cmd <= io_InputBuffer[5:0];
        pend_arg <= '0;
      end else if (state == ST_ARG) begin
        pend_arg <= (pend_arg << 8) | ARG_W'(io_InputBuffer);
      end
    end
  end

  // Registered outputs: pulses last one cycle, command/argument/data are held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_CommandValid    <= 1'b0;
      io_Command         <= 6'd0;
      io_CommandArgument <= '0;
      io_FrameError      <= 1'b0;
      io_DataOut         <= 8'd0;
      io_DataValid       <= 1'b0;
      io_DataDone        <= 1'b0;
    end else begin
      io_CommandValid <= 1'b0;
      io_FrameError   <= 1'b0;
      io_DataValid    <= 1'b0;
      io_DataDone     <= 1'b0;
      if (strobe) begin
        case (state)
          ST_CRC: begin
            if (frame_ok) begin
              io_CommandValid    <= 1'b1;
              io_Command         <= pend_cmd;
              io_CommandArgument <= pend_arg;
            end else begin
              io_FrameError <= 1'b1;
            end
          end
          ST_TOKEN: begin
            if (token_bad) io_FrameError <= 1'b1;
          end
          ST_DATA: begin
            io_DataOut   <= io_InputBuffer;
            io_DataValid <= 1'b1;
          end
          ST_DCRC: begin
            if (dcrc_cnt) io_DataDone <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
